modexp_arbiter: RTL and testbench

Round-robin scheduler that shares one `mont_modexp` engine between `NREQ` independent requesters. Accepts one request at a time, launches the engine with a single-cycle `start`, waits for `done`, and returns the result on a shared response channel tagged with the requester ID. Sits between client blocks (key-exchange and signature front-ends) and the engine instance; the engine's `WIDTH`/`MOD`/`NPRIME`/`R2MOD` are configured at the engine, not here.

---
 rtl/modexp_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/modexp_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_modexp_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_arb_pkg.sv
// Shared state encoding and sizing helper for the shared modexp engine scheduler.
package modexp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Requester-ID width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest-index requester at or after ptr wins.
// Returns a one-hot grant plus its binary index; reusable by any shared-engine scheduler.
module rr_arbiter
  import modexp_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  localparam int unsigned SW = IDW + 1;

  logic [NREQ-1:0] req_rot;
  logic [SW-1:0]   slot;
  logic            found;

  // Rotate so ptr sits at bit 0, take the first set bit, then map back.
  always_comb begin
    req_rot  = NREQ'({req, req} >> ptr);
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    slot     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        slot  = SW'(ptr) + SW'(i);
        if (slot >= SW'(NREQ)) begin
          slot = slot - SW'(NREQ);
        end
        grant_id = IDW'(slot);
      end
    end
    if (found) begin
      grant = NREQ'(1) << grant_id;
    end
  end

endmodule

// File: rtl/modexp_arbiter.sv
// Round-robin scheduler sharing one mont_modexp engine between NREQ requesters.
// Optional watchdog in WAIT enabled by defining MODEXP_ARB_TIMEOUT_EN.
module modexp_arbiter
  import modexp_arb_pkg::*;
#(
  parameter  int unsigned WIDTH          = 32,
  parameter  int unsigned NREQ           = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 16384,
  localparam int unsigned IDW            = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_base,
  input  logic [NREQ*WIDTH-1:0] req_exp,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_base,
  output logic [WIDTH-1:0]      eng_exp,
  input  logic                  eng_done,
  input  logic [WIDTH-1:0]      eng_result
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             wait_first_q, wait_first_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             timeout_hit;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

`ifdef MODEXP_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNTW-1:0] cnt_q, cnt_d;

  // Counts WAIT cycles, including the ignored first one.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  // Next-state, operand capture and grant generation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    base_d       = base_q;
    exp_d        = exp_q;
    result_d     = result_q;
    err_d        = err_q;
    wait_first_d = 1'b0;
    start_d      = 1'b0;
    req_ready    = '0;

    case (state_q)
      ST_IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready = grant;
          id_d      = grant_id;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              base_d = req_base[i*WIDTH +: WIDTH];
              exp_d  = req_exp[i*WIDTH +: WIDTH];
            end
          end
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wait_first_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A done seen in the first WAIT cycle may belong to the previous job.
        if (eng_done && !wait_first_q) begin
          result_d = eng_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (timeout_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      base_q       <= '0;
      exp_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      wait_first_q <= 1'b0;
      start_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      base_q       <= base_d;
      exp_q        <= exp_d;
      result_q     <= result_d;
      err_q        <= err_d;
      wait_first_q <= wait_first_d;
      start_q      <= start_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid  = valid_q;
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;
  assign busy        = busy_q;
  assign eng_start   = start_q;
  assign eng_base    = base_q;
  assign eng_exp     = exp_q;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Bench for modexp_arbiter: behavioural engine (MOD 998244353) plus a cycle-timed
// transaction model of the scheduling rules; directed scenarios then random traffic.
module tb_modexp_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;
  localparam int          TMO   = 16;
  localparam longint unsigned MODV = 64'd998244353;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_base;
  logic [NREQ*WIDTH-1:0] req_exp;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_result;
  logic                  resp_err;
  logic                  busy;
  logic                  eng_start;
  logic [WIDTH-1:0]      eng_base;
  logic [WIDTH-1:0]      eng_exp;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_result;

  modexp_arbiter #(
    .WIDTH          (WIDTH),
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_base    (req_base),
    .req_exp     (req_exp),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy),
    .eng_start   (eng_start),
    .eng_base    (eng_base),
    .eng_exp     (eng_exp),
    .eng_done    (eng_done),
    .eng_result  (eng_result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // requester side
  bit          rq_v [NREQ];
  logic [31:0] rq_b [NREQ];
  logic [31:0] rq_e [NREQ];
  bit          granted [NREQ];
  int p_raise = 0, p_drop = 0, p_ready = 100, p_spur = 0;

  // engine side
  bit          hold_done = 1'b0, never_done = 1'b0;
  bit          e_job = 1'b0;
  int          e_due = 0;
  logic [31:0] e_res = '0;

  // reference model
  int          cyc = 0;
  bit          op_active = 1'b0, done_seen = 1'b0, after_rst = 1'b1;
  int          acc_cyc = 0, m_ptr = 0, m_id = 0;
  logic [31:0] m_base = '0, m_exp = '0, m_ref = '0, m_res = '0;
  bit          m_err = 1'b0;

  // observations
  int          log_id [$];
  logic [31:0] log_res [$];
  logic        log_err [$];
  int          n_starts = 0, rv_cycles = 0, rdy_cycles = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e);
    longint unsigned r = 1;
    longint unsigned x = 64'(b) % MODV;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % MODV;
      x = (x * x) % MODV;
    end
    return 32'(r);
  endfunction

  function automatic int pick(input int ptr);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (rq_v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check registered outputs, drive inputs, check grant, advance model.
  task automatic step(input bit do_rst);
    logic [NREQ-1:0] exp_ready;
    int w;
    bit drv_done;
    @(negedge clk);
    cyc++;
    if (eng_start === 1'b1) n_starts++;
    if (resp_valid === 1'b1) rv_cycles++;

    check_eq("busy", busy, op_active);
    check_eq("eng_start", eng_start, op_active && (cyc == acc_cyc + 1));
    check_eq("resp_valid", resp_valid, op_active && done_seen);
    if (op_active) begin
      check_eq("eng_base", eng_base, m_base);
      check_eq("eng_exp", eng_exp, m_exp);
    end
    if (op_active && done_seen) begin
      check_eq("resp_id", resp_id, m_id);
      check_eq("resp_result", resp_result, m_res);
      check_eq("resp_err", resp_err, m_err);
    end
    if (after_rst) begin
      check_eq("rst_resp_id", resp_id, 0);
      check_eq("rst_resp_result", resp_result, 0);
      check_eq("rst_resp_err", resp_err, 0);
      check_eq("rst_eng_base", eng_base, 0);
      check_eq("rst_eng_exp", eng_exp, 0);
    end

    // engine model reacts to the DUT's start pulse
    if (eng_start === 1'b1) begin
      e_job = 1'b1;
      e_due = cyc + (hold_done ? 2 : int'($urandom_range(10, 2)));
      e_res = ref_modexp(eng_base, eng_exp);
    end
    drv_done = 1'b0;
    if (hold_done) drv_done = 1'b1;
    else if (e_job && !never_done && cyc == e_due) drv_done = 1'b1;
    else if (!(op_active && !done_seen && cyc >= acc_cyc + 3) && $urandom_range(99) < p_spur)
      drv_done = 1'b1;
    eng_done   = drv_done;
    eng_result = (e_job && !never_done && cyc >= e_due) ? e_res : $urandom;

    for (int i = 0; i < int'(NREQ); i++) begin
      if (granted[i]) begin
        rq_v[i] = 1'b0;
        granted[i] = 1'b0;
      end else if (rq_v[i]) begin
        if ($urandom_range(99) < p_drop) rq_v[i] = 1'b0;
      end else if ($urandom_range(99) < p_raise) begin
        rq_v[i] = 1'b1;
        rq_b[i] = $urandom;
        rq_e[i] = ($urandom_range(3) == 0) ? 32'($urandom_range(20)) : $urandom;
      end
      req_valid[i] = rq_v[i];
      req_base[i*WIDTH +: WIDTH] = rq_b[i];
      req_exp[i*WIDTH +: WIDTH]  = rq_e[i];
    end
    resp_ready = ($urandom_range(99) < p_ready);
    rst = do_rst;
    #1;

    exp_ready = '0;
    w = -1;
    if (!do_rst && !op_active) begin
      w = pick(m_ptr);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    check_eq("req_ready", req_ready, exp_ready);
    if (req_ready !== '0) rdy_cycles++;

    if (do_rst) begin
      op_active = 1'b0;
      done_seen = 1'b0;
      m_ptr     = 0;
      e_job     = 1'b0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (op_active && done_seen) begin
        if (resp_ready) begin
          log_id.push_back(int'(resp_id));
          log_res.push_back(resp_result);
          log_err.push_back(resp_err);
          m_ptr     = (m_id + 1) % NREQ;
          op_active = 1'b0;
          done_seen = 1'b0;
        end
      end else if (op_active) begin
        if (drv_done && cyc >= acc_cyc + 3) begin
          done_seen = 1'b1;
          m_res     = m_ref;
          m_err     = 1'b0;
        end
`ifdef MODEXP_ARB_TIMEOUT_EN
        else if (cyc == acc_cyc + 1 + TMO) begin
          done_seen = 1'b1;
          m_res     = '0;
          m_err     = 1'b1;
        end
`endif
      end else if (w >= 0) begin
        op_active  = 1'b1;
        acc_cyc    = cyc;
        m_id       = w;
        m_base     = rq_b[w];
        m_exp      = rq_e[w];
        m_ref      = ref_modexp(rq_b[w], rq_e[w]);
        granted[w] = 1'b1;
      end
    end
  endtask

  task automatic run_until(input int nlog, input int budget);
    int k = 0;
    while (log_id.size() < nlog && k < budget) begin
      step(1'b0);
      k++;
    end
    check_eq("resp_count", log_id.size(), nlog);
  endtask

  task automatic do_reset();
    step(1'b1);
    step(1'b1);
    log_id.delete();
    log_res.delete();
    log_err.delete();
  endtask

  task automatic set_req(input int i, input logic [31:0] b, input logic [31:0] e);
    rq_v[i] = 1'b1;
    rq_b[i] = b;
    rq_e[i] = e;
  endtask

  initial begin
    int k;
    int s0;
    rst = 1'b1;
    req_valid = '0;
    req_base = '0;
    req_exp = '0;
    resp_ready = 1'b0;
    eng_done = 1'b0;
    eng_result = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rq_v[i] = 1'b0;
      rq_b[i] = '0;
      rq_e[i] = '0;
      granted[i] = 1'b0;
    end

    do_reset();

    // single request from requester 2
    s0 = n_starts;
    set_req(2, 32'd2, 32'd10);
    run_until(1, 60);
    if (log_id.size() >= 1) begin
      check_eq("single_id", log_id[0], 2);
      check_eq("single_res", log_res[0], 1024);
      check_eq("single_err", log_err[0], 0);
    end
    check_eq("single_starts", n_starts - s0, 1);
    repeat (3) step(1'b0);

    // contention from reset: 0, 1, 3 served in index order
    set_req(0, 32'd3, 32'd4);
    set_req(1, 32'd5, 32'd13);
    set_req(3, 32'd998244352, 32'd3);
    do_reset();
    run_until(3, 120);
    if (log_id.size() >= 3) begin
      check_eq("cont_id0", log_id[0], 0);
      check_eq("cont_id1", log_id[1], 1);
      check_eq("cont_id2", log_id[2], 3);
      check_eq("cont_res0", log_res[0], 81);
      check_eq("cont_res1", log_res[1], 222458772); // 5^13 = 1220703125, minus one modulus
      check_eq("cont_res2", log_res[2], 998244352);
    end

    // fairness: pointer wrapped after 3, so 0 precedes 3
    log_id.delete(); log_res.delete(); log_err.delete();
    set_req(3, 32'd11, 32'd2);
    set_req(0, 32'd12, 32'd2);
    run_until(2, 80);
    if (log_id.size() >= 2) begin
      check_eq("fair_first", log_id[0], 0);
      check_eq("fair_second", log_id[1], 3);
      check_eq("fair_res", log_res[1], 121);
    end

    // backpressure with a competing requester waiting
    log_id.delete(); log_res.delete(); log_err.delete();
    p_ready = 0;
    set_req(1, 32'd7, 32'd5);
    k = 0;
    while (!(op_active && done_seen) && k < 40) begin step(1'b0); k++; end
    set_req(2, 32'd6, 32'd3);
    rdy_cycles = 0;
    repeat (5) step(1'b0);
    check_eq("bp_no_grant", rdy_cycles, 0);
    check_eq("bp_valid_held", resp_valid, 1);
    p_ready = 100;
    run_until(2, 80);
    if (log_id.size() >= 2) begin
      check_eq("bp_res", log_res[0], 16807);
      check_eq("bp_next_id", log_id[1], 2);
      check_eq("bp_next_res", log_res[1], 216);
    end

    // engine holding done high: result only taken after the first WAIT cycle
    log_id.delete(); log_res.delete(); log_err.delete();
    hold_done = 1'b1;
    set_req(0, 32'd3, 32'd7);
    run_until(1, 40);
    if (log_res.size() >= 1) check_eq("stale_res", log_res[0], 2187);
    hold_done = 1'b0;
    repeat (2) step(1'b0);

    // reset while waiting on the engine aborts the request
    log_id.delete(); log_res.delete(); log_err.delete();
    set_req(3, 32'd9, 32'd9);
    k = 0;
    while (!(op_active && cyc >= acc_cyc + 2) && k < 20) begin step(1'b0); k++; end
    check_eq("abort_in_wait", busy, 1);
    step(1'b1);
    rv_cycles = 0;
    repeat (20) step(1'b0);
    check_eq("abort_no_resp", rv_cycles, 0);
    set_req(3, 32'd9, 32'd9);
    run_until(1, 40);
    if (log_id.size() >= 1) begin
      check_eq("rereq_id", log_id[0], 3);
      check_eq("rereq_res", log_res[0], 387420489);
    end

`ifdef MODEXP_ARB_TIMEOUT_EN
    // watchdog: engine never answers
    log_id.delete(); log_res.delete(); log_err.delete();
    never_done = 1'b1;
    set_req(1, 32'd4, 32'd4);
    run_until(1, 80);
    if (log_id.size() >= 1) begin
      check_eq("tmo_err", log_err[0], 1);
      check_eq("tmo_res", log_res[0], 0);
    end
    never_done = 1'b0;
    repeat (2) step(1'b0);
`endif

    // random traffic with drops, spurious done pulses, backpressure and rare resets
    p_raise = 20;
    p_drop  = 3;
    p_ready = 70;
    p_spur  = 15;
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(999) < 2);
    end
    p_raise = 0;
    p_drop  = 0;
    p_ready = 100;
    for (int i = 0; i < int'(NREQ); i++) rq_v[i] = 1'b0;
    k = 0;
    while (op_active && k < 60) begin step(1'b0); k++; end
    step(1'b0);
    check_eq("drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
